// File: rtl/line_follow_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : line_follow_sequencer
// Description : Tape-following rover navigation controller. Synchronises and
//               debounces the three IPS sensor bits, then runs the drive FSM
//               (follow, lost-tape search, scripted intersection turns, halt)
//               and issues registered run/direction commands to the PWM stage.
// Revision    : 1.0 - initial release
// ============================================================================
module line_follow_sequencer #(
    parameter int unsigned FILT_CYCLES  = 100000,
    parameter int unsigned LOST_TIMEOUT = 50000000,
    parameter int unsigned TURN_CYCLES  = 30000000,
    parameter logic [7:0]  TURN_PATTERN = 8'b11_01_10_00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [2:0] ips,
    output logic       run,
    output logic [1:0] direction,
    output logic [2:0] state,
    output logic [1:0] turn_idx,
    output logic [2:0] ips_filt
);

    // Terminal counts for the filter and the shared state timer
    localparam logic [16:0] c_FILT_LAST = 17'(FILT_CYCLES - 1);
    localparam logic [25:0] c_LOST_LAST = 26'(LOST_TIMEOUT - 1);
    localparam logic [25:0] c_TURN_LAST = 26'(TURN_CYCLES - 1);

    // State encoding (also shown on the LEDs)
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_FOLLOW = 3'd1;
    localparam logic [2:0] c_ST_SEARCH = 3'd2;
    localparam logic [2:0] c_ST_TURN   = 3'd3;
    localparam logic [2:0] c_ST_HALT   = 3'd4;

    // Direction command encoding
    localparam logic [1:0] c_DIR_FWD   = 2'd0;
    localparam logic [1:0] c_DIR_BACK  = 2'd1;
    localparam logic [1:0] c_DIR_LEFT  = 2'd2;
    localparam logic [1:0] c_DIR_RIGHT = 2'd3;

    // Side of the tape last seen while following
    localparam logic [1:0] c_SIDE_NONE   = 2'd0;
    localparam logic [1:0] c_SIDE_LEFT   = 2'd1;
    localparam logic [1:0] c_SIDE_RIGHT  = 2'd2;
    localparam logic [1:0] c_SIDE_CENTER = 2'd3;

    // Intersection actions stored in TURN_PATTERN
    localparam logic [1:0] c_ACT_STRAIGHT = 2'd0;
    localparam logic [1:0] c_ACT_LEFT     = 2'd1;
    localparam logic [1:0] c_ACT_RIGHT    = 2'd2;
    localparam logic [1:0] c_ACT_HALT     = 2'd3;

    logic [2:0]  r_ips_s1;
    logic [2:0]  r_ips_s2;
    logic [16:0] r_filt_cnt;
    logic [2:0]  r_ips_filt;

    logic [2:0]  r_state;
    logic        r_run;
    logic [1:0]  r_direction;
    logic [1:0]  r_turn_idx;
    logic [1:0]  r_last_side;
    logic [25:0] r_timer;

    logic [1:0]  w_action;
    logic [1:0]  w_turn_dir;
    logic [1:0]  w_search_dir;
    logic [25:0] w_timer_inc;

    assign run       = r_run;
    assign direction = r_direction;
    assign state     = r_state;
    assign turn_idx  = r_turn_idx;
    assign ips_filt  = r_ips_filt;

    // Next scripted action and the steering command it maps to
    assign w_action = TURN_PATTERN[{r_turn_idx, 1'b0} +: 2];

    always_comb begin
        w_turn_dir = c_DIR_FWD;
        case (w_action)
            c_ACT_STRAIGHT: w_turn_dir = c_DIR_FWD;
            c_ACT_LEFT:     w_turn_dir = c_DIR_LEFT;
            c_ACT_RIGHT:    w_turn_dir = c_DIR_RIGHT;
            default:        w_turn_dir = c_DIR_FWD;
        endcase
    end

    // Search rotates toward the side the tape was last seen on, else backs up
    always_comb begin
        w_search_dir = c_DIR_BACK;
        case (r_last_side)
            c_SIDE_RIGHT: w_search_dir = c_DIR_RIGHT;
            c_SIDE_LEFT:  w_search_dir = c_DIR_LEFT;
            default:      w_search_dir = c_DIR_BACK;
        endcase
    end

    // Timer never wraps: it sticks at all-ones
    assign w_timer_inc = (r_timer == '1) ? r_timer : r_timer + 26'd1;

    // Two-flop synchroniser followed by a run-length debounce filter.
    // Change detection looks one stage ahead of the sampled value so the
    // filtered output follows a stable input after FILT_CYCLES+2 edges.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ips_s1   <= 3'b000;
            r_ips_s2   <= 3'b000;
            r_filt_cnt <= '0;
            r_ips_filt <= 3'b000;
        end else begin
            r_ips_s1 <= ips;
            r_ips_s2 <= r_ips_s1;
            if (r_ips_s1 != r_ips_s2) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == c_FILT_LAST) begin
                r_ips_filt <= r_ips_s2;
            end else begin
                r_filt_cnt <= r_filt_cnt + 17'd1;
            end
        end
    end

    // Drive state machine with registered run/direction commands
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_run       <= 1'b0;
            r_direction <= c_DIR_FWD;
            r_turn_idx  <= 2'd0;
            r_last_side <= c_SIDE_NONE;
            r_timer     <= '0;
        end else if (!enable) begin
            r_state     <= c_ST_IDLE;
            r_run       <= 1'b0;
            r_direction <= c_DIR_FWD;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_state     <= c_ST_FOLLOW;
                    r_run       <= 1'b1;
                    r_direction <= c_DIR_FWD;
                end

                c_ST_FOLLOW: begin
                    case (r_ips_filt)
                        3'b010: begin
                            r_direction <= c_DIR_FWD;
                            r_last_side <= c_SIDE_CENTER;
                        end
                        3'b011: begin
                            r_direction <= c_DIR_FWD;
                            r_last_side <= c_SIDE_RIGHT;
                        end
                        3'b110: begin
                            r_direction <= c_DIR_FWD;
                            r_last_side <= c_SIDE_LEFT;
                        end
                        3'b001: begin
                            r_direction <= c_DIR_RIGHT;
                            r_last_side <= c_SIDE_RIGHT;
                        end
                        3'b100: begin
                            r_direction <= c_DIR_LEFT;
                            r_last_side <= c_SIDE_LEFT;
                        end
                        3'b111: begin
                            r_turn_idx <= r_turn_idx + 2'd1;
                            if (w_action == c_ACT_HALT) begin
                                r_state     <= c_ST_HALT;
                                r_run       <= 1'b0;
                                r_direction <= c_DIR_FWD;
                            end else begin
                                r_state     <= c_ST_TURN;
                                r_direction <= w_turn_dir;
                                r_timer     <= '0;
                            end
                        end
                        3'b101: begin
                            r_state     <= c_ST_HALT;
                            r_run       <= 1'b0;
                            r_direction <= c_DIR_FWD;
                        end
                        default: begin
                            r_state     <= c_ST_SEARCH;
                            r_direction <= w_search_dir;
                            r_timer     <= '0;
                        end
                    endcase
                end

                c_ST_SEARCH: begin
                    if (r_ips_filt != 3'b000) begin
                        r_state <= c_ST_FOLLOW;
                    end else if (r_timer == c_LOST_LAST) begin
                        r_state     <= c_ST_HALT;
                        r_run       <= 1'b0;
                        r_direction <= c_DIR_FWD;
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end

                c_ST_TURN: begin
                    if (r_timer == c_TURN_LAST) begin
                        r_state <= c_ST_FOLLOW;
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end

                c_ST_HALT: begin
                    r_run       <= 1'b0;
                    r_direction <= c_DIR_FWD;
                end

                default: begin
                    r_state     <= c_ST_IDLE;
                    r_run       <= 1'b0;
                    r_direction <= c_DIR_FWD;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_line_follow_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_follow_sequencer
// Description : Scoreboard bench for line_follow_sequencer. Expected output
//               values are queued with their due cycle when stimulus is
//               applied and compared when that cycle arrives.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_follow_sequencer;

    localparam int c_SEL_STATE = 0;
    localparam int c_SEL_RUN   = 1;
    localparam int c_SEL_DIR   = 2;
    localparam int c_SEL_IDX   = 3;
    localparam int c_SEL_FILT  = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [2:0] ips;
    logic       run;
    logic [1:0] direction;
    logic [2:0] state;
    logic [1:0] turn_idx;
    logic [2:0] ips_filt;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    int          q_cyc[$];
    int          q_sel[$];
    logic [31:0] q_exp[$];
    string       q_tag[$];

    logic [7:0] r_pattern = 8'b11_01_10_00;

    line_follow_sequencer #(
        .FILT_CYCLES (4),
        .LOST_TIMEOUT(20),
        .TURN_CYCLES (10),
        .TURN_PATTERN(8'b11_01_10_00)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .ips      (ips),
        .run      (run),
        .direction(direction),
        .state    (state),
        .turn_idx (turn_idx),
        .ips_filt (ips_filt)
    );

    // 100 MHz clock
    always #5 clock = ~clock;

    // Edge counter used to schedule expectations
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, required %0d", tag, cyc, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            c_SEL_STATE: observe = {29'd0, state};
            c_SEL_RUN:   observe = {31'd0, run};
            c_SEL_DIR:   observe = {30'd0, direction};
            c_SEL_IDX:   observe = {30'd0, turn_idx};
            default:     observe = {29'd0, ips_filt};
        endcase
    endfunction

    // Intersection action to steering command
    function automatic logic [1:0] act_dir(input logic [1:0] a);
        if (a == 2'd1)      act_dir = 2'd2;
        else if (a == 2'd2) act_dir = 2'd3;
        else                act_dir = 2'd0;
    endfunction

    task automatic sb_push(input int due, input int sel, input logic [31:0] v, input string tag);
        q_cyc.push_back(due);
        q_sel.push_back(sel);
        q_exp.push_back(v);
        q_tag.push_back(tag);
    endtask

    task automatic sb_compare();
        for (int i = q_cyc.size() - 1; i >= 0; i--) begin
            if (q_cyc[i] == cyc) begin
                check_val(q_tag[i], observe(q_sel[i]), q_exp[i]);
                q_cyc.delete(i);
                q_sel.delete(i);
                q_exp.delete(i);
                q_tag.delete(i);
            end
        end
    endtask

    // Advance n cycles, scoring due expectations on each falling edge
    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(negedge clock);
            sb_compare();
        end
    endtask

    task automatic intersection(input int k);
        int t;
        logic [1:0] a;
        a = r_pattern[2*k +: 2];
        t = cyc;
        ips = 3'b111;
        if (a == 2'd3) begin
            sb_push(t + 7, c_SEL_STATE, 4, "isect_halt_state");
            sb_push(t + 7, c_SEL_RUN, 0, "isect_halt_run");
            sb_push(t + 7, c_SEL_IDX, 32'((k + 1) % 4), "isect_halt_idx");
        end else begin
            sb_push(t + 6, c_SEL_STATE, 1, "isect_pre_follow");
            sb_push(t + 7, c_SEL_STATE, 3, "turn_state");
            sb_push(t + 7, c_SEL_DIR, 32'(act_dir(a)), "turn_dir");
            sb_push(t + 7, c_SEL_IDX, 32'((k + 1) % 4), "turn_idx");
            sb_push(t + 16, c_SEL_STATE, 3, "turn_hold_state");
            sb_push(t + 16, c_SEL_DIR, 32'(act_dir(a)), "turn_hold_dir");
            sb_push(t + 17, c_SEL_STATE, 1, "turn_done");
        end
        wait_cyc(6);
        ips = 3'b010;
        wait_cyc(14);
    endtask

    initial begin
        int t;
        reset  = 1'b1;
        enable = 1'b0;
        ips    = 3'b000;

        // Reset state
        wait_cyc(2);
        t = cyc;
        sb_push(t + 1, c_SEL_STATE, 0, "rst_state");
        sb_push(t + 1, c_SEL_RUN, 0, "rst_run");
        sb_push(t + 1, c_SEL_DIR, 0, "rst_dir");
        sb_push(t + 1, c_SEL_IDX, 0, "rst_idx");
        sb_push(t + 1, c_SEL_FILT, 0, "rst_filt");
        wait_cyc(1);
        reset = 1'b0;
        wait_cyc(2);

        // Filter latency and glitch rejection
        t = cyc;
        ips = 3'b010;
        sb_push(t + 5, c_SEL_FILT, 0, "filt_early");
        sb_push(t + 6, c_SEL_FILT, 2, "filt_latency");
        wait_cyc(8);
        t = cyc;
        ips = 3'b001;
        for (int k = 1; k <= 10; k++) sb_push(t + k, c_SEL_FILT, 2, "filt_glitch");
        wait_cyc(3);
        ips = 3'b010;
        wait_cyc(9);

        // Enable into FOLLOW
        t = cyc;
        enable = 1'b1;
        sb_push(t + 1, c_SEL_STATE, 1, "follow_state");
        sb_push(t + 1, c_SEL_RUN, 1, "follow_run");
        sb_push(t + 1, c_SEL_DIR, 0, "follow_dir");
        sb_push(t + 3, c_SEL_DIR, 0, "follow_fwd");
        wait_cyc(4);

        // Right-of-centre then lost tape: search right, timeout to HALT
        t = cyc;
        ips = 3'b011;
        sb_push(t + 8, c_SEL_DIR, 0, "follow_011_fwd");
        wait_cyc(10);
        t = cyc;
        ips = 3'b000;
        sb_push(t + 6, c_SEL_STATE, 1, "pre_search");
        sb_push(t + 7, c_SEL_STATE, 2, "search_entry");
        sb_push(t + 7, c_SEL_DIR, 3, "search_dir_right");
        sb_push(t + 7, c_SEL_RUN, 1, "search_run");
        sb_push(t + 26, c_SEL_STATE, 2, "search_before_timeout");
        sb_push(t + 27, c_SEL_STATE, 4, "timeout_halt");
        sb_push(t + 27, c_SEL_RUN, 0, "timeout_halt_run");
        wait_cyc(30);
        t = cyc;
        enable = 1'b0;
        sb_push(t + 1, c_SEL_STATE, 0, "halt_to_idle");
        wait_cyc(2);

        // Scripted intersections
        ips = 3'b010;
        wait_cyc(8);
        t = cyc;
        enable = 1'b1;
        sb_push(t + 1, c_SEL_STATE, 1, "rearm_follow");
        wait_cyc(3);
        for (int k = 0; k < 4; k++) intersection(k);

        // Reset in the middle of a turn
        t = cyc;
        enable = 1'b0;
        wait_cyc(1);
        enable = 1'b1;
        sb_push(t + 2, c_SEL_STATE, 1, "rearm_after_halt");
        wait_cyc(3);
        t = cyc;
        ips = 3'b111;
        sb_push(t + 7, c_SEL_STATE, 3, "turn_before_reset");
        sb_push(t + 7, c_SEL_IDX, 1, "idx_before_reset");
        wait_cyc(6);
        ips = 3'b010;
        wait_cyc(4);
        t = cyc;
        reset  = 1'b1;
        enable = 1'b0;
        sb_push(t + 1, c_SEL_STATE, 0, "midturn_rst_state");
        sb_push(t + 1, c_SEL_RUN, 0, "midturn_rst_run");
        sb_push(t + 1, c_SEL_DIR, 0, "midturn_rst_dir");
        sb_push(t + 1, c_SEL_IDX, 0, "midturn_rst_idx");
        sb_push(t + 1, c_SEL_FILT, 0, "midturn_rst_filt");
        wait_cyc(1);
        reset = 1'b0;
        wait_cyc(10);

        // Advance turn_idx to 1 for the later checks
        enable = 1'b1;
        wait_cyc(3);
        intersection(0);

        // Tape reappears on the timeout cycle
        t = cyc;
        ips = 3'b000;
        sb_push(t + 7, c_SEL_STATE, 2, "search2_entry");
        sb_push(t + 7, c_SEL_DIR, 1, "search_dir_back");
        wait_cyc(20);
        ips = 3'b100;
        sb_push(t + 26, c_SEL_FILT, 4, "filt_at_timeout");
        sb_push(t + 26, c_SEL_STATE, 2, "search_at_timeout");
        sb_push(t + 27, c_SEL_STATE, 1, "tape_wins");
        sb_push(t + 27, c_SEL_RUN, 1, "tape_wins_run");
        sb_push(t + 28, c_SEL_DIR, 2, "follow_left");
        wait_cyc(10);

        // 101 halts; one-cycle enable drop re-arms with turn_idx kept
        t = cyc;
        ips = 3'b101;
        sb_push(t + 7, c_SEL_STATE, 4, "halt_101");
        sb_push(t + 7, c_SEL_RUN, 0, "halt_101_run");
        wait_cyc(9);
        t = cyc;
        enable = 1'b0;
        sb_push(t + 1, c_SEL_STATE, 0, "drop_idle");
        sb_push(t + 1, c_SEL_IDX, 1, "idx_kept_idle");
        wait_cyc(1);
        enable = 1'b1;
        sb_push(t + 2, c_SEL_STATE, 1, "rearm_follow2");
        sb_push(t + 2, c_SEL_RUN, 1, "rearm_run2");
        sb_push(t + 2, c_SEL_IDX, 1, "idx_kept_follow");
        sb_push(t + 3, c_SEL_STATE, 4, "rehalt_101");
        wait_cyc(5);

        check_val("sb_drained", 32'(q_cyc.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout, required finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/line_follow_sequencer.md
Name: line_follow_sequencer

Overview:
Top-level navigation controller for the tape-following rover. It filters the three IPS sensor bits and runs the drive state machine: follow, lost-tape search, scripted T-intersection turns and halt. It issues registered run/direction commands to the existing PWM/driver-board stage, where run=1 selects the switch-chosen duty width.

Parameters:
FILT_CYCLES, 100000, consecutive identical IPS samples required before the filtered value updates (1 ms at 100 MHz)
LOST_TIMEOUT, 50000000, maximum cycles spent in SEARCH before giving up (0.5 s)
TURN_CYCLES, 30000000, cycles the scripted intersection manoeuvre runs
TURN_PATTERN, 8'b11_01_10_00, four 2-bit intersection actions; entry k is bits [2k+1:2k]. 0=straight, 1=left, 2=right, 3=halt

Ports:
clock  in  1  system clock, 100 MHz
reset  in  1  synchronous, active-high reset
enable  in  1  run request (SW0); level sensitive
ips  in  3  raw sensor bits, already active-high {L,C,R}; asynchronous to clock
run  out  1  1 = motors driven at the selected duty; 0 = width 0
direction  out  2  0=fwd, 1=back, 2=rotate left, 3=rotate right
state  out  3  current state code, for LEDs
turn_idx  out  2  index of the next TURN_PATTERN entry
ips_filt  out  3  filtered sensor value

Behaviour:
- One clock; reset is synchronous and active-high.
- All outputs are registered. On reset: run=0, direction=0, state=IDLE, turn_idx=0, ips_filt=000, filter/timer counters=0, last_side=NONE.
- Input stage: two-flop synchroniser on ips, then filter.
  - Filter counter clears whenever the synchronised value differs from the previous sample.
  - When the counter reaches FILT_CYCLES-1 with an unchanged sample, ips_filt loads that sample on the next edge.
  - Latency from a stable ips change to ips_filt: FILT_CYCLES+2 cycles.
- State codes: IDLE=0, FOLLOW=1, SEARCH=2, TURN=3, HALT=4. run and direction reflect the state entered on the same edge.
- enable=0 in any state: go to IDLE next edge with run=0 and direction=0. turn_idx is kept; only reset clears it. This rule has priority over all other transitions.
- IDLE: run=0. If enable=1, go to FOLLOW.
- FOLLOW: run=1. Decode ips_filt as follows:
  - 010, 011, 110: fwd.
  - 001: rotate right.
  - 100: rotate left.
  - last_side update: 011/001 set RIGHT, 110/100 set LEFT, 010 sets CENTER.
  - 111 (intersection):
    - Read a = TURN_PATTERN[turn_idx].
    - turn_idx increments mod 4, wrapping 3 to 0.
    - If a=3, go to HALT.
    - Otherwise go to TURN with direction {0 to fwd, 1 to left, 2 to right} and timer cleared.
  - 101: go to HALT.
  - 000: go to SEARCH with timer cleared. direction is RIGHT to rotate right, LEFT to rotate left, CENTER/NONE to back.
- SEARCH: direction is held and the timer increments.
  - If ips_filt is not 000, go to FOLLOW and decode on the following cycle.
  - Otherwise, when the timer reaches LOST_TIMEOUT-1, go to HALT.
  - If tape reappears on the same cycle the timeout expires, tape wins and the state goes to FOLLOW.
- TURN: direction is held and ips_filt is ignored.
  - When the timer reaches TURN_CYCLES-1, go to FOLLOW.
  - A 111 still present on return is treated as a new intersection. Intersections must be wider than the turn distance covered.
- HALT: run=0, direction=0. Stay until enable=0, then go to IDLE. Re-arming requires an enable 0→1 transition.
- Timer is 26 bits wide and saturates; it never wraps.
- Filter counter is 17 bits wide.

Test Plan:
(Bench parameters: FILT_CYCLES=4, LOST_TIMEOUT=20, TURN_CYCLES=10, TURN_PATTERN default.)
1. Reset asserted mid-TURN → next edge: run=0, state=0, turn_idx=0, ips_filt=000.
2. enable=1, ips=010 stable → ips_filt=010 exactly 6 cycles later, then state=1, run=1, direction=0. Toggle ips to 001 for 3 cycles then back to 010 → ips_filt never shows 001.
3. Steady 011, then 000 → SEARCH, direction=3. Hold 000 for the full timeout → HALT exactly 20 cycles after entry, run=0. Set enable=0 → state=0.
4. Four 111 intersections, separated by 010 → turn_idx sequence 1,2,3,0.
   - Intersection 1: direction=0 for 10 cycles.
   - Intersection 2: direction=3 for 10 cycles.
   - Intersection 3: direction=2 for 10 cycles.
   - Intersection 4: HALT.
5. In SEARCH, ips_filt becomes 100 on the cycle the timer reaches 19 → state=FOLLOW, not HALT.
6. ips_filt=101 in FOLLOW → HALT. enable dropped for 1 cycle, then raised → IDLE → FOLLOW, with turn_idx unchanged.
